// File: rtl/hopfield_pkg.sv
// Shared constants and types for the Hopfield recall path.
package hopfield_pkg;

    localparam int unsigned N_NEURONS = 7;
    localparam int unsigned PATTERN_W = 4;
    localparam int unsigned CNT_WIDTH = 8;
    localparam int unsigned WIN_WIDTH = 16;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        StIdle,
        StIntegrate,
        StDecide,
        StHold
    } dec_state_e;

endpackage

// File: rtl/spike_edge_counter.sv
// One neuron's rising-edge detector feeding a saturating edge counter.
module spike_edge_counter
    import hopfield_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             spike,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             at_max
);

    logic spike_q;
    logic spike_edge;

    assign spike_edge = spike & ~spike_q;
    assign at_max     = (count == {CNT_W{1'b1}});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            spike_q <= 1'b0;
            count   <= '0;
        end else begin
            // Edge history tracks the input in every state so the first window cycle is exact.
            spike_q <= spike;
            if (clear) begin
                count <= '0;
            end else if (enable && spike_edge && !at_max) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spike_pattern_decoder.sv
// Counts spike edges per neuron over a window and thresholds them into a recalled pattern.
module spike_pattern_decoder
    import hopfield_pkg::*;
#(
    parameter int unsigned N     = N_NEURONS,
    parameter int unsigned PAT_W = PATTERN_W,
    parameter int unsigned CNT_W = CNT_WIDTH,
    parameter int unsigned WIN_W = WIN_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [N-1:0]     spikes,
    input  logic [WIN_W-1:0] window_len,
    input  logic [CNT_W-1:0] threshold,
    output logic             busy,
    output logic [PAT_W-1:0] pattern_out,
    output logic [N-1:0]     active_mask,
    output logic [2:0]       winner,
    output logic             saturated,
    output logic             pattern_valid,
    input  logic             pattern_ready
);

    dec_state_e       state_q, state_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0] thr_q;
    logic [CNT_W-1:0] count [N];
    logic [N-1:0]     at_max;
    logic             clear;
    logic             enable;
    logic             load_result;
    logic [N-1:0]     mask_d;
    logic [2:0]       winner_d;
    logic [CNT_W-1:0] best;

    for (genvar i = 0; i < N; i++) begin : g_cnt
        spike_edge_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk    (clk),
            .reset_n(reset_n),
            .spike  (spikes[i]),
            .clear  (clear),
            .enable (enable),
            .count  (count[i]),
            .at_max (at_max[i])
        );
    end

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        mask_d   = '0;
        winner_d = 3'd0;
        best     = count[0];
        for (int i = 0; i < N; i++) begin
            mask_d[i] = (count[i] >= thr_q);
        end
        for (int i = 1; i < N; i++) begin
            if (count[i] > best) begin
                best     = count[i];
                winner_d = 3'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        win_cnt_d   = win_cnt_q;
        clear       = 1'b0;
        enable      = 1'b0;
        load_result = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    clear     = 1'b1;
                    win_cnt_d = (window_len == '0) ? WIN_W'(1) : window_len;
                    state_d   = StIntegrate;
                end
            end
            StIntegrate: begin
                enable    = 1'b1;
                win_cnt_d = win_cnt_q - 1'b1;
                if (win_cnt_q == WIN_W'(1)) begin
                    state_d = StDecide;
                end
            end
            StDecide: begin
                load_result = 1'b1;
                state_d     = StHold;
            end
            StHold: begin
                if (pattern_valid && pattern_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy = (state_q != StIdle);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            win_cnt_q     <= '0;
            thr_q         <= '0;
            pattern_out   <= '0;
            active_mask   <= '0;
            winner        <= 3'd0;
            saturated     <= 1'b0;
            pattern_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_cnt_q <= win_cnt_d;
            if (clear) begin
                thr_q <= threshold;
            end
            if (load_result) begin
                pattern_out   <= mask_d[PAT_W-1:0];
                active_mask   <= mask_d;
                winner        <= winner_d;
                // Counters never decrement within a window, so a max count now means it was hit.
                saturated     <= |at_max;
                pattern_valid <= 1'b1;
            end else if (state_q == StHold && pattern_ready) begin
                pattern_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spike_pattern_decoder.sv
// Directed self-checking bench for spike_pattern_decoder.
module tb_spike_pattern_decoder;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [6:0]  spikes;
    logic [15:0] window_len;
    logic [7:0]  threshold;
    logic        busy;
    logic [3:0]  pattern_out;
    logic [6:0]  active_mask;
    logic [2:0]  winner;
    logic        saturated;
    logic        pattern_valid;
    logic        pattern_ready;

    int checks;
    int failures;

    spike_pattern_decoder u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .spikes       (spikes),
        .window_len   (window_len),
        .threshold    (threshold),
        .busy         (busy),
        .pattern_out  (pattern_out),
        .active_mask  (active_mask),
        .winner       (winner),
        .saturated    (saturated),
        .pattern_valid(pattern_valid),
        .pattern_ready(pattern_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag, input logic [3:0] pat, input logic [6:0] mask,
                                input logic [2:0] win, input logic sat);
        check({tag, ".pattern_out"}, 16'(pattern_out), 16'(pat));
        check({tag, ".active_mask"}, 16'(active_mask), 16'(mask));
        check({tag, ".winner"}, 16'(winner), 16'(win));
        check({tag, ".saturated"}, 16'(saturated), 16'(sat));
    endtask

    initial begin
        logic [6:0] s;
        checks        = 0;
        failures      = 0;
        reset_n       = 1'b0;
        start         = 1'b0;
        spikes        = '0;
        window_len    = '0;
        threshold     = '0;
        pattern_ready = 1'b0;
        step();
        step();
        check("reset.busy", 16'(busy), 16'd0);
        check("reset.valid", 16'(pattern_valid), 16'd0);
        check_result("reset", 4'b0000, 7'b0000000, 3'd0, 1'b0);
        reset_n = 1'b1;
        step();

        // Test 1: neurons 0 and 2 five edges, neuron 5 two edges.
        window_len = 16'd10;
        threshold  = 8'd3;
        start      = 1'b1;
        step();
        start = 1'b0;
        check("t1.busy_after_start", 16'(busy), 16'd1);
        for (int c = 1; c <= 10; c++) begin
            s    = '0;
            s[0] = (c % 2 == 1);
            s[2] = (c % 2 == 1);
            s[5] = (c == 2) || (c == 6);
            spikes = s;
            step();
        end
        spikes = '0;
        check("t1.valid_cycle11", 16'(pattern_valid), 16'd0);
        step();
        check("t1.valid_cycle12", 16'(pattern_valid), 16'd1);
        check_result("t1", 4'b0101, 7'b0000101, 3'd0, 1'b0);
        pattern_ready = 1'b1;
        step();
        pattern_ready = 1'b0;
        check("t1.valid_after_hs", 16'(pattern_valid), 16'd0);
        check("t1.busy_after_hs", 16'(busy), 16'd0);
        check_result("t1.kept", 4'b0101, 7'b0000101, 3'd0, 1'b0);

        // Test 2: level held high counts once; window/threshold changes after start ignored.
        window_len = 16'd10;
        threshold  = 8'd1;
        start      = 1'b1;
        step();
        start      = 1'b0;
        window_len = 16'd3;
        threshold  = 8'd0;
        for (int c = 1; c <= 10; c++) begin
            spikes = 7'b0000010;
            step();
        end
        spikes = '0;
        check("t2.valid_cycle11", 16'(pattern_valid), 16'd0);
        check("t2.busy_cycle11", 16'(busy), 16'd1);
        step();
        check("t2.valid_cycle12", 16'(pattern_valid), 16'd1);
        check_result("t2", 4'b0010, 7'b0000010, 3'd1, 1'b0);
        pattern_ready = 1'b1;
        step();
        pattern_ready = 1'b0;

        // Test 3: neuron 6 gets 300 edges and clamps at 255, neuron 3 gets 150.
        window_len = 16'd600;
        threshold  = 8'd200;
        start      = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 600; c++) begin
            s    = '0;
            s[6] = (c % 2 == 1);
            s[3] = (c % 4 == 1);
            spikes = s;
            step();
        end
        spikes = '0;
        step();
        check("t3.valid", 16'(pattern_valid), 16'd1);
        check_result("t3", 4'b0000, 7'b1000000, 3'd6, 1'b1);

        // Test 4: back-pressure with spike activity and start pulses.
        for (int k = 0; k < 5; k++) begin
            spikes = (k % 2 == 0) ? 7'h7f : 7'h00;
            start  = (k % 2 == 0);
            step();
            check("t4.hold_valid", 16'(pattern_valid), 16'd1);
            check("t4.hold_busy", 16'(busy), 16'd1);
            check_result("t4.hold", 4'b0000, 7'b1000000, 3'd6, 1'b1);
        end
        pattern_ready = 1'b1;
        start         = 1'b1;
        spikes        = '0;
        step();
        start = 1'b0;
        check("t4.valid_after_hs", 16'(pattern_valid), 16'd0);
        check("t4.busy_after_hs", 16'(busy), 16'd0);
        step();
        check("t4.start_in_hs_ignored", 16'(busy), 16'd0);
        pattern_ready = 1'b0;

        // Test 5: window_len 0 acts as 1, threshold 0 makes every bit active.
        window_len = 16'd0;
        threshold  = 8'd0;
        start      = 1'b1;
        step();
        start = 1'b0;
        check("t5.busy_cycle1", 16'(busy), 16'd1);
        step();
        check("t5.valid_cycle2", 16'(pattern_valid), 16'd0);
        step();
        check("t5.valid_cycle3", 16'(pattern_valid), 16'd1);
        check_result("t5", 4'b1111, 7'b1111111, 3'd0, 1'b0);
        pattern_ready = 1'b1;
        step();
        pattern_ready = 1'b0;
        check("t5.busy_after_hs", 16'(busy), 16'd0);

        // Test 6: asynchronous reset mid-window, then a clean short window.
        window_len = 16'd20;
        threshold  = 8'd1;
        start      = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            spikes = (c % 2 == 1) ? 7'b0010000 : 7'b0000000;
            step();
        end
        spikes  = '0;
        reset_n = 1'b0;
        #2;
        check("t6.reset_busy", 16'(busy), 16'd0);
        check("t6.reset_valid", 16'(pattern_valid), 16'd0);
        check_result("t6.reset", 4'b0000, 7'b0000000, 3'd0, 1'b0);
        step();
        reset_n = 1'b1;
        step();
        check("t6.idle_after_release", 16'(busy), 16'd0);
        window_len = 16'd4;
        threshold  = 8'd1;
        start      = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            spikes = (c == 2) ? 7'b0001000 : 7'b0000000;
            step();
        end
        spikes = '0;
        check("t6.valid_cycle5", 16'(pattern_valid), 16'd0);
        step();
        check("t6.valid_cycle6", 16'(pattern_valid), 16'd1);
        check_result("t6", 4'b1000, 7'b0001000, 3'd3, 1'b0);
        pattern_ready = 1'b1;
        step();
        check("t6.busy_after_hs", 16'(busy), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
